// File: rtl/cga_pkg.sv
// rtl/cga_pkg.sv - shared mode encodings, colour and word-length constants for the CGA pixel path
package cga_pkg;

  typedef enum logic [1:0] {
    MODE_TEXT = 2'd0,
    MODE_320  = 2'd1,
    MODE_640  = 2'd2,
    MODE_RSVD = 2'd3
  } mode_e;

  localparam logic [3:0] IRGB_BLACK = 4'h0;

  localparam int WORD_LEN_NARROW = 8;
  localparam int WORD_LEN_WIDE   = 16;

  function automatic logic [3:0] last_pix(mode_e m);
    return (m == MODE_640) ? 4'(WORD_LEN_WIDE - 1) : 4'(WORD_LEN_NARROW - 1);
  endfunction

endpackage

// File: rtl/cga_pixel_decode.sv
// rtl/cga_pixel_decode.sv - combinational word/index to IRGB decode for text, 320 and 640 modes
// Optional CGA_PIXEL_SHIFTER_CURSOR_EN adds a cursor input that forces text pixels to fg.
module cga_pixel_decode
  import cga_pkg::*;
(
  input  logic [15:0] word,
  input  logic [3:0]  idx,
  input  logic [1:0]  mode,
  input  logic        palette,
  input  logic        blink_en,
  input  logic        blink_phase,
  input  logic [4:0]  color_sel,
`ifdef CGA_PIXEL_SHIFTER_CURSOR_EN
  input  logic        cursor,
`endif
  output logic [3:0]  irgb
);

  logic [7:0] attr;
  logic [7:0] glyph;
  logic [3:0] fg;
  logic [3:0] bg;
  logic [3:0] base;
  logic [1:0] v;

  always_comb begin
    attr  = word[15:8];
    glyph = word[7:0];
    bg    = {blink_en ? 1'b0 : attr[7], attr[6:4]};
    fg    = attr[3:0];
    // Blinking characters vanish into the background during the hidden phase
    if (blink_en && attr[7] && blink_phase) fg = bg;
    base  = 4'd15 - {idx[2:0], 1'b0};
    v     = word[base -: 2];
    case (mode)
      MODE_320: irgb = (v == 2'd0) ? color_sel[3:0] : {color_sel[4], v, palette};
      MODE_640: irgb = word[4'd15 - idx] ? color_sel[3:0] : IRGB_BLACK;
      default:  irgb = glyph[3'd7 - idx[2:0]] ? fg : bg;
    endcase
`ifdef CGA_PIXEL_SHIFTER_CURSOR_EN
    if (cursor && (mode == MODE_TEXT)) irgb = attr[3:0];
`endif
  end

endmodule

// File: rtl/cga_pixel_shifter.sv
// rtl/cga_pixel_shifter.sv - 1-entry holding register plus word shifter producing registered IRGB pixels
// Optional CGA_PIXEL_SHIFTER_CURSOR_EN adds the per-word text cursor input.
module cga_pixel_shifter
  import cga_pkg::*;
#(
  parameter logic [3:0] UNDERRUN_COLOR = 4'h0,
  parameter bit         BORDER_IN_640  = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pix_ce,
  input  logic [15:0] word_data,
  input  logic        word_valid,
  output logic        word_ready,
  input  logic [1:0]  mode,
  input  logic        display_en,
  input  logic [4:0]  color_sel,
  input  logic        palette,
  input  logic        blink_en,
  input  logic        blink_phase,
  input  logic        bw,
  output logic [3:0]  video,
  output logic        composite,
  output logic        underrun
`ifdef CGA_PIXEL_SHIFTER_CURSOR_EN
  ,
  input  logic        cursor
`endif
);

  logic [15:0] hold_q, hold_d;
  logic        hold_full_q, hold_full_d;
  logic [15:0] shift_q, shift_d;
  logic        shift_full_q, shift_full_d;
  logic [3:0]  cnt_q, cnt_d;
  mode_e       mode_q, mode_d;
  logic        palette_q, palette_d;
  logic        blink_en_q, blink_en_d;
  logic [3:0]  video_q, video_d;
  logic        composite_q, composite_d;
  logic        underrun_q, underrun_d;
  logic        cursor_cur;
`ifdef CGA_PIXEL_SHIFTER_CURSOR_EN
  logic        cursor_q, cursor_d;
`endif

  logic        xfer;
  logic        take_hold;
  logic        bypass;
  logic [3:0]  pix_irgb;

  always_comb begin
    hold_d       = hold_q;
    hold_full_d  = hold_full_q;
    shift_d      = shift_q;
    shift_full_d = shift_full_q;
    cnt_d        = cnt_q;
    mode_d       = mode_q;
    palette_d    = palette_q;
    blink_en_d   = blink_en_q;
    composite_d  = composite_q;
    underrun_d   = 1'b0;
    xfer         = 1'b0;
    take_hold    = 1'b0;
    bypass       = 1'b0;
`ifdef CGA_PIXEL_SHIFTER_CURSOR_EN
    cursor_d     = cursor_q;
`endif
    if (pix_ce) begin
      xfer = !shift_full_q || (cnt_q == last_pix(mode_q));
      if (xfer) begin
        take_hold = hold_full_q;
        bypass    = !hold_full_q && word_valid;
        if (take_hold || bypass) begin
          shift_d      = take_hold ? hold_q : word_data;
          shift_full_d = 1'b1;
          cnt_d        = 4'd0;
          mode_d       = (mode == MODE_RSVD) ? MODE_TEXT : mode_e'(mode);
          palette_d    = palette;
          blink_en_d   = blink_en;
          composite_d  = bw && (mode == MODE_640);
`ifdef CGA_PIXEL_SHIFTER_CURSOR_EN
          cursor_d     = cursor;
`endif
        end else begin
          shift_full_d = 1'b0;
          underrun_d   = 1'b1;
        end
      end else begin
        cnt_d = cnt_q + 4'd1;
      end
    end
    if (take_hold) hold_full_d = 1'b0;
    // A word taken by bypass never lands in the holding register
    if (word_valid && !hold_full_q && !bypass) begin
      hold_d      = word_data;
      hold_full_d = 1'b1;
    end
  end

`ifdef CGA_PIXEL_SHIFTER_CURSOR_EN
  assign cursor_cur = cursor_d;
`else
  assign cursor_cur = 1'b0;
`endif

  cga_pixel_decode u_decode (
    .word        (shift_d),
    .idx         (cnt_d),
    .mode        (mode_d),
    .palette     (palette_d),
    .blink_en    (blink_en_d),
    .blink_phase (blink_phase),
    .color_sel   (color_sel),
`ifdef CGA_PIXEL_SHIFTER_CURSOR_EN
    .cursor      (cursor_cur),
`endif
    .irgb        (pix_irgb)
  );

  always_comb begin
    video_d = video_q;
    if (pix_ce) begin
      if (!display_en) begin
        video_d = ((mode_d == MODE_640) && !BORDER_IN_640) ? IRGB_BLACK : color_sel[3:0];
      end else if (!shift_full_d) begin
        video_d = UNDERRUN_COLOR;
      end else begin
        video_d = pix_irgb;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hold_q       <= 16'h0;
      hold_full_q  <= 1'b0;
      shift_q      <= 16'h0;
      shift_full_q <= 1'b0;
      cnt_q        <= 4'd0;
      mode_q       <= MODE_TEXT;
      palette_q    <= 1'b0;
      blink_en_q   <= 1'b0;
      video_q      <= 4'h0;
      composite_q  <= 1'b0;
      underrun_q   <= 1'b0;
`ifdef CGA_PIXEL_SHIFTER_CURSOR_EN
      cursor_q     <= 1'b0;
`endif
    end else begin
      hold_q       <= hold_d;
      hold_full_q  <= hold_full_d;
      shift_q      <= shift_d;
      shift_full_q <= shift_full_d;
      cnt_q        <= cnt_d;
      mode_q       <= mode_d;
      palette_q    <= palette_d;
      blink_en_q   <= blink_en_d;
      video_q      <= video_d;
      composite_q  <= composite_d;
      underrun_q   <= underrun_d;
`ifdef CGA_PIXEL_SHIFTER_CURSOR_EN
      cursor_q     <= cursor_d;
`endif
    end
  end

  assign word_ready = !hold_full_q;
  assign video      = video_q;
  assign composite  = composite_q;
  assign underrun   = underrun_q;

endmodule

// File: doc/cga_pixel_shifter.md
Name: cga_pixel_shifter

Overview:
- Source end of the 4-bit IRGB video stream consumed by the VGA/composite colour converter.
- Accepts 16-bit display words (text char+attr row, or two graphics bytes) from the CRTC/VRAM fetch path through a valid/ready handshake.
- Serializes each word into per-pixel IRGB codes on a pixel clock enable, and emits the composite-mode flag aligned to 8-pixel word boundaries.

Parameters:
- UNDERRUN_COLOR, 4'h0, IRGB code driven while the shifter is starved.
- BORDER_IN_640, 0, 1: border in 640 mode = color_sel[3:0]; 0: border in 640 mode = black.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- pix_ce  in  1  pixel clock enable; one pixel per asserted cycle
- word_data  in  16  text: {attr[15:8], glyph_row[7:0]}; graphics: {byte0[15:8], byte1[7:0]}
- word_valid  in  1  word_data valid
- word_ready  out  1  holding register can accept a word
- mode  in  2  0 = text, 1 = 320x200 4-colour, 2 = 640x200 2-colour, 3 = reserved (treated as 0)
- display_en  in  1  active area; 0 = border
- color_sel  in  5  CGA colour-select register: [3:0] colour, [4] intensity
- palette  in  1  320 mode: 0 = green/red/brown, 1 = cyan/magenta/white
- blink_en  in  1  text attr[7] is blink (1) or bg intensity (0)
- blink_phase  in  1  blink clock, 1 = hidden phase
- bw  in  1  mono/composite-enable request
- video  out  4  IRGB pixel
- composite  out  1  composite lookup enable, changes only at word boundaries
- underrun  out  1  one-cycle pulse per starved word slot

Behaviour:
- Reset values: video = 0, composite = 0, word_ready = 1, holding empty, shifter empty, pixel counter = 0, underrun = 0.
- Holding register (1 entry): word_ready = ~hold_full. Load on word_valid & word_ready.
- Shifter: 16-bit register plus pixel counter. Word length is 8 pixels (modes 0, 1) or 16 pixels (mode 2).
- Transfer: on pix_ce when the counter is at the last pixel, or the shifter is empty:
  - Holding moves into the shifter; counter goes to 0.
  - mode, palette, blink_en, bw are latched per word.
  - Bypass: if holding is empty and word_valid is high in the same cycle, word_data loads straight into the shifter; word_ready stays 1.
  - Holding empty and no valid: shifter marked empty, underrun pulses for 1 cycle, video = UNDERRUN_COLOR until the next successful transfer.
  - A simultaneous holding load and transfer is legal; the holding register ends full only if it received the new word.
- Pixel decode (registered, 1 cycle latency after pix_ce; video holds between pix_ce):
  - text: pixel bit = glyph_row[7-n].
    - fg = attr[11:8]; bg = {blink_en ? 0 : attr[15], attr[14:12]}.
    - If blink_en & attr[15] & blink_phase, fg is forced to bg.
  - 320: 2-bit value v = shifter[15-2n -: 2].
    - v = 0 gives color_sel[3:0].
    - Otherwise the code is {color_sel[4], palette ? {v, 1} : {v, 0}} with bits mapped to IRGB as I, R = v[1], G = v[0], B = palette ? 1 : 0. Examples: palette 0, v = 1 → 4'h2; palette 1, v = 3 → 4'h7.
  - 640: bit = shifter[15-n]; 1 → color_sel[3:0], 0 → 4'h0.
- Border: display_en = 0, sampled each pix_ce, gives video = color_sel[3:0] (640 mode with BORDER_IN_640 = 0 gives 4'h0).
  - The shifter keeps advancing during border, so upstream must not supply words during border; any supplied words are consumed.
- composite = latched bw & (latched mode == 2). Updates only at transfer, so composite lookups see whole 8-pixel groups.
- Mode change mid-word takes effect at the next transfer.
- Reset mid-word discards the holding and shifter contents immediately.

Optional Feature:
- CGA_PIXEL_SHIFTER_CURSOR_EN: adds input `cursor` (1 bit), sampled at transfer.
  - Text mode only: while the latched cursor is 1, all 8 pixels of that word output fg, ignoring the glyph and blink.
  - Without the macro: port absent, no cursor logic.

Decomposition:
- Package cga_pkg:
  - mode encodings MODE_TEXT / MODE_320 / MODE_640.
  - IRGB colour constants.
  - Word-length constants 8/16.
- One natural sub-module, cga_pixel_decode: combinational mode/palette/attr → IRGB. The shifter, holding register and handshake stay in the top.

Test Plan:
- Text, word 16'h1E81, blink_en = 0, continuous pix_ce → video 4'hE, then 4'h1 ×6, then 4'hE; word_ready reasserts after the transfer.
- 320, palette = 1, color_sel = 5'h11, word 16'h1B00 → 4'h1, 4'hB, 4'hD, 4'hF, then 4'h1 ×4.
- 640, bw = 1, color_sel = 4'hF, word 16'hAAAA → alternating F/0 for 16 pixels; composite rises only at the word transfer.
- word_valid low at a transfer → underrun one-cycle pulse, video = UNDERRUN_COLOR; next valid word is bypassed into the shifter the same cycle.
- Text, attr bit7 = 1, blink_en = 1, blink_phase = 1 → all pixels equal bg; blink_phase = 0 → glyph visible.
- Reset asserted at pixel 3 of a word → next cycle video = 0, word_ready = 1, composite = 0.
